// File: rtl/timer_display_mux_if.sv
// rtl/timer_display_mux_if.sv - digit/flag inputs and segment/anode outputs of timer_display_mux
interface timer_display_mux_if;
    logic [3:0] TensBinaryIn;
    logic [3:0] UnitsBinaryIn;
    logic       FinTIn;
    logic       DispEn;
    logic [6:0] Seg;
    logic [1:0] Anode;

    modport master (
        output TensBinaryIn, UnitsBinaryIn, FinTIn, DispEn,
        input  Seg, Anode
    );

    modport slave (
        input  TensBinaryIn, UnitsBinaryIn, FinTIn, DispEn,
        output Seg, Anode
    );
endinterface

// File: rtl/timer_display_mux.sv
// rtl/timer_display_mux.sv - two-digit 7-segment scan mux with expiry blink
// Optional macro LEADING_ZERO_BLANK_EN blanks the tens slot when the tens digit is 0.
module timer_display_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_HALF  = 250
) (
    input logic               clk,
    input logic               rst,
    timer_display_mux_if.slave bus
);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [1:0] IDLE       = 2'd0;
    localparam logic [1:0] SCAN_UNITS = 2'd1;
    localparam logic [1:0] SCAN_TENS  = 2'd2;

    logic [1:0]    state;
    logic [RW-1:0] refreshCnt;
    logic [BW-1:0] blinkCnt;
    logic          blinkOn;
    logic [3:0]    tensSh;
    logic [3:0]    unitsSh;
    logic          scanTick;

    assign scanTick = (state != IDLE) && (refreshCnt == RW'(REFRESH_DIV - 1));

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h3F;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            refreshCnt <= '0;
            blinkCnt   <= '0;
            blinkOn    <= 1'b1;
            tensSh     <= 4'd0;
            unitsSh    <= 4'd0;
        end else begin
            if (state == IDLE) begin
                refreshCnt <= '0;
                if (bus.DispEn) begin
                    state   <= SCAN_UNITS;
                    tensSh  <= bus.TensBinaryIn;
                    unitsSh <= bus.UnitsBinaryIn;
                end
            end else if (!bus.DispEn) begin
                state      <= IDLE;
                refreshCnt <= '0;
            end else if (scanTick) begin
                refreshCnt <= '0;
                // Both digits are resampled only at a frame boundary so a frame never mixes samples.
                if (state == SCAN_TENS) begin
                    state   <= SCAN_UNITS;
                    tensSh  <= bus.TensBinaryIn;
                    unitsSh <= bus.UnitsBinaryIn;
                end else begin
                    state <= SCAN_TENS;
                end
            end else begin
                refreshCnt <= refreshCnt + 1'b1;
            end

            if (!bus.FinTIn || (state != IDLE && !bus.DispEn)) begin
                blinkCnt <= '0;
                blinkOn  <= 1'b1;
            end else if (scanTick) begin
                if (blinkCnt == BW'(BLINK_HALF - 1)) begin
                    blinkCnt <= '0;
                    blinkOn  <= !blinkOn;
                end else begin
                    blinkCnt <= blinkCnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || state == IDLE || !blinkOn) begin
            bus.Seg   <= 7'h7F;
            bus.Anode <= 2'b11;
        end else if (state == SCAN_TENS) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (tensSh == 4'd0) begin
                bus.Seg   <= 7'h7F;
                bus.Anode <= 2'b11;
            end else begin
                bus.Seg   <= decode(tensSh);
                bus.Anode <= 2'b01;
            end
`else
            bus.Seg   <= decode(tensSh);
            bus.Anode <= 2'b01;
`endif
        end else begin
            bus.Seg   <= decode(unitsSh);
            bus.Anode <= 2'b10;
        end
    end
endmodule

// File: tb/tb_timer_display_mux.sv
// tb/tb_timer_display_mux.sv - directed and random checks of timer_display_mux against a frame-level model
module tb_timer_display_mux;
    localparam int DIV = 4;
    localparam int BH  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    timer_display_mux_if bus ();

    timer_display_mux #(.REFRESH_DIV(DIV), .BLINK_HALF(BH)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    bit       mScan     = 1'b0;
    int       mCyc      = 0;
    int       mFinTicks = 0;
    logic [3:0] mT = 4'd0;
    logic [3:0] mU = 4'd0;

    function automatic logic [6:0] segOf(input logic [3:0] d);
        logic [6:0] tab [16];
        tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
        return tab[d];
    endfunction

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chkLit(input string tag, input logic [6:0] s, input logic [1:0] a);
        chk({tag, "_seg"}, {2'b0, bus.Seg}, {2'b0, s});
        chk({tag, "_anode"}, {7'b0, bus.Anode}, {7'b0, a});
    endtask

    task automatic drive(input logic r, input logic de, input logic fin,
                         input logic [3:0] t, input logic [3:0] u);
        rst               = r;
        bus.DispEn        = de;
        bus.FinTIn        = fin;
        bus.TensBinaryIn  = t;
        bus.UnitsBinaryIn = u;
    endtask

    // One clock: expected output comes from the model as it stood before the edge.
    task automatic step();
        logic [6:0] eS;
        logic [1:0] eA;
        int  slot;
        bit  tick;
        slot = (mCyc / DIV) % 2;
        eS = 7'h7F;
        eA = 2'b11;
        if (!rst && mScan && ((mFinTicks / BH) % 2) == 0) begin
            if (slot == 0) begin
                eS = segOf(mU);
                eA = 2'b10;
            end else begin
`ifdef LEADING_ZERO_BLANK_EN
                if (mT != 4'd0) begin
                    eS = segOf(mT);
                    eA = 2'b01;
                end
`else
                eS = segOf(mT);
                eA = 2'b01;
`endif
            end
        end
        @(posedge clk);
        if (rst) begin
            mScan = 1'b0; mCyc = 0; mFinTicks = 0; mT = 4'd0; mU = 4'd0;
        end else if (!mScan) begin
            if (bus.DispEn) begin
                mScan = 1'b1; mCyc = 0;
                mT = bus.TensBinaryIn; mU = bus.UnitsBinaryIn;
            end
            if (!bus.FinTIn) mFinTicks = 0;
        end else if (!bus.DispEn) begin
            mScan = 1'b0; mCyc = 0; mFinTicks = 0;
        end else begin
            tick = (mCyc % DIV) == DIV - 1;
            if (tick && slot == 1) begin
                mT = bus.TensBinaryIn; mU = bus.UnitsBinaryIn;
            end
            if (!bus.FinTIn) mFinTicks = 0;
            else if (tick) mFinTicks++;
            mCyc++;
        end
        #1;
        chk("seg", {2'b0, bus.Seg}, {2'b0, eS});
        chk("anode", {7'b0, bus.Anode}, {7'b0, eA});
        chk("anode_both_low", {8'b0, bus.Anode == 2'b00}, 9'd0);
    endtask

    initial begin
        drive(1'b1, 1'b1, 1'b0, 4'd2, 4'd9);
        step();
        step();
        chkLit("reset_state", 7'h7F, 2'b11);

        drive(1'b0, 1'b1, 1'b0, 4'd2, 4'd9);
        step();
        step();
        chkLit("units_29", 7'h10, 2'b10);
        repeat (3) step();
        step();
        chkLit("tens_29", 7'h24, 2'b01);

        drive(1'b0, 1'b1, 1'b0, 4'd2, 4'd8);
        repeat (3) step();
        step();
        chkLit("units_after_change", 7'h00, 2'b10);
        repeat (12) step();

        drive(1'b0, 1'b1, 1'b0, 4'd2, 4'd12);
        repeat (20) step();

        drive(1'b0, 1'b1, 1'b1, 4'd0, 4'd0);
        repeat (48) step();
        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
        repeat (6) step();

        drive(1'b0, 1'b1, 1'b0, 4'd0, 4'd5);
        repeat (20) step();

        drive(1'b0, 1'b0, 1'b0, 4'd7, 4'd3);
        repeat (3) step();
        drive(1'b0, 1'b1, 1'b1, 4'd7, 4'd3);
        repeat (10) step();
        drive(1'b1, 1'b1, 1'b1, 4'd7, 4'd3);
        step();
        drive(1'b0, 1'b1, 1'b1, 4'd4, 4'd1);
        repeat (12) step();

        for (int i = 0; i < 900; i++) begin
            logic r, de, fin;
            logic [3:0] t, u;
            r   = rst;
            de  = bus.DispEn;
            fin = bus.FinTIn;
            t   = bus.TensBinaryIn;
            u   = bus.UnitsBinaryIn;
            r = ($urandom_range(99) < 2);
            if ($urandom_range(99) < 4) de = ~de;
            if (!de && $urandom_range(99) < 30) de = 1'b1;
            if ($urandom_range(99) < 3) fin = ~fin;
            if ($urandom_range(99) < 10) t = 4'($urandom_range(15));
            if ($urandom_range(99) < 10) u = 4'($urandom_range(15));
            drive(r, de, fin, t, u);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
